// File: rtl/seg_scan_60.sv
// seg_scan_60 -- two-digit multiplexed 7-segment scanner for a 00..59 seconds
// counter, with a decimal-point flash after each carry.
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (2..2^20)
//   CO_HOLD   scan frames the decimal point stays lit after a carry (1..15)
//
// Ports
//   clk    in   sole clock, rising edge
//   rst    in   asynchronous reset, active low
//   count  in   BCD seconds, [6:4] tens, [3:0] ones
//   co     in   carry level from the upstream counter
//   seg    out  segments {g,f,e,d,c,b,a}, active low, registered
//   dp     out  decimal point, active low, registered
//   an     out  digit enables, active low: an[0] ones, an[1] tens
//
// Build option
//   LEAD_ZERO_BLANK_EN  when defined, a tens digit of 0 is blanked (an[1]
//                       is still driven low so the dp can still show).
//
// A frame is a ones slot followed by a tens slot. count is sampled once per
// frame into a shadow register so both digits always come from one value.
// Display registers update on the cycle after each prescaler tick.

module seg_scan_60 #(
   parameter int SCAN_DIV = 50000,
   parameter int CO_HOLD  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] count,
   input  logic       co,
   output logic [6:0] seg,
   output logic       dp,
   output logic [1:0] an
);

   localparam int            PW      = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PMAX    = PW'(SCAN_DIV - 1);
   localparam logic [3:0]    HOLD_LD = 4'(CO_HOLD);
   localparam logic [6:0]    DASH    = 7'b0111111;
   localparam logic [6:0]    BLANK   = 7'b1111111;

   logic [PW-1:0] presc;
   logic          tick;
   logic          tick_d;
   logic          sel;
   logic          armed;
   logic          frame_start;
   logic [6:0]    shadow;
   logic          co_q;
   logic          co_edge;
   logic [3:0]    hold;
   logic          dp_frame;
   logic [6:0]    seg_next;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = DASH;
      endcase
   endfunction

   assign tick    = (presc == PMAX);
   assign co_edge = co & ~co_q;

   // The very first tick after reset is treated as a frame start so the
   // display always comes up in the ones slot with a freshly sampled count.
   assign frame_start = tick & (sel | ~armed);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc    <= '0;
         tick_d   <= 1'b0;
         sel      <= 1'b0;
         armed    <= 1'b0;
         shadow   <= '0;
         co_q     <= 1'b0;
         hold     <= '0;
         dp_frame <= 1'b0;
      end else begin
         presc  <= tick ? '0 : presc + 1'b1;
         tick_d <= tick;
         co_q   <= co;
         if (tick) begin
            sel   <= ~frame_start;
            armed <= 1'b1;
         end
         // dp for a whole frame is decided from hold as it stands entering
         // the frame, so CO_HOLD loads give exactly CO_HOLD lit frames.
         if (frame_start) begin
            shadow   <= count;
            dp_frame <= (hold != 4'd0);
         end
         if (co_edge)
            hold <= HOLD_LD;
         else if (frame_start && hold != 4'd0)
            hold <= hold - 1'b1;
      end
   end

   always_comb begin
      seg_next = BLANK;
      if (sel) begin
         if (shadow[6:4] > 3'd5)
            seg_next = DASH;
         else
            seg_next = glyph({1'b0, shadow[6:4]});
`ifdef LEAD_ZERO_BLANK_EN
         if (shadow[6:4] == 3'd0)
            seg_next = BLANK;
`else
`endif
      end else begin
         seg_next = glyph(shadow[3:0]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         seg <= BLANK;
         dp  <= 1'b1;
         an  <= 2'b11;
      end else if (tick_d) begin
         seg <= seg_next;
         an  <= sel ? 2'b01 : 2'b10;
         dp  <= ~dp_frame;
      end
   end

endmodule

// File: tb/tb_seg_scan_60.sv
// Directed bench for seg_scan_60 with SCAN_DIV=4, CO_HOLD=2.
// Timeline after each reset release (at negedge N0): display slots change on
// the posedges P5, P9, P13, ...; ones slot visible N5..N8, tens N9..N12, etc.
// count is sampled at frame-start posedges P4, P12, P20, ...

module tb_seg_scan_60;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] count = 7'h00;
   logic       co = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] an;

   int errors = 0;
   int checks = 0;

   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] GD = 7'b0111111;
   localparam logic [6:0] GB = 7'b1111111;

   seg_scan_60 #(.SCAN_DIV(4), .CO_HOLD(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .count (count),
      .co    (co),
      .seg   (seg),
      .dp    (dp),
      .an    (an)
   );

   always #5 clk = ~clk;

   task automatic go(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at negedge N0 with reset just released.
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      go(2);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      count = 7'h37;
      do_reset();
      go(6);
      // asynchronous assertion mid-cycle, away from any clock edge
      #2 rst = 1'b0;
      #1;
      checks++; if (seg !== GB) begin errors++; $display("FAIL reset_seg got=%b exp=%b", seg, GB); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
      checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_an got=%b exp=11", an); end
      go(2);
      rst = 1'b1;
      go(4);
      checks++; if (an !== 2'b11) begin errors++; $display("FAIL reset_dark_n4 got=%b exp=11", an); end
   endtask

   task automatic test_basic();
      count = 7'h37;
      do_reset();
      go(5);
      checks++; if (an !== 2'b10) begin errors++; $display("FAIL basic_an_n5 got=%b exp=10", an); end
      checks++; if (seg !== G7) begin errors++; $display("FAIL basic_seg_n5 got=%b exp=%b", seg, G7); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL basic_dp_n5 got=%b exp=1", dp); end
      go(3);
      checks++; if (an !== 2'b10) begin errors++; $display("FAIL basic_an_n8 got=%b exp=10", an); end
      go(1);
      checks++; if (an !== 2'b01) begin errors++; $display("FAIL basic_an_n9 got=%b exp=01", an); end
      checks++; if (seg !== G3) begin errors++; $display("FAIL basic_seg_n9 got=%b exp=%b", seg, G3); end
      go(4);
      checks++; if (an !== 2'b10 || seg !== G7) begin errors++; $display("FAIL basic_n13 got=%b/%b exp=10/%b", an, seg, G7); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL basic_dp_n13 got=%b exp=1", dp); end
   endtask

   task automatic test_freeze();
      count = 7'h12;
      do_reset();
      go(5);
      checks++; if (seg !== G2) begin errors++; $display("FAIL freeze_ones0 got=%b exp=%b", seg, G2); end
      go(5);
      count = 7'h45;
      go(2);
      checks++; if (an !== 2'b01 || seg !== G1) begin errors++; $display("FAIL freeze_tens0 got=%b/%b exp=01/%b", an, seg, G1); end
      go(1);
      checks++; if (an !== 2'b10 || seg !== G5) begin errors++; $display("FAIL freeze_ones1 got=%b/%b exp=10/%b", an, seg, G5); end
      go(4);
      checks++; if (an !== 2'b01 || seg !== G4) begin errors++; $display("FAIL freeze_tens1 got=%b/%b exp=01/%b", an, seg, G4); end
   endtask

   task automatic test_carry();
      int lit;
      count = 7'h00;
      do_reset();
      go(10);
      co = 1'b1;
      go(1);
      co = 1'b0;
      go(1);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL carry_dp_n12 got=%b exp=1", dp); end
      lit = 0;
      for (int i = 0; i < 24; i++) begin
         go(1);
         if (dp === 1'b0) lit++;
      end
      // N13..N36 sampled: lit on N13..N28
      checks++; if (lit != 16) begin errors++; $display("FAIL carry_dp_len got=%0d exp=16", lit); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL carry_dp_after got=%b exp=1", dp); end
   endtask

   task automatic test_co_at_frame_start();
      count = 7'h00;
      do_reset();
      go(11);
      co = 1'b1;
      go(1);
      co = 1'b0;
      go(8);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL cofs_dp_n20 got=%b exp=1", dp); end
      go(1);
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL cofs_dp_n21 got=%b exp=0", dp); end
      go(15);
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL cofs_dp_n36 got=%b exp=0", dp); end
      go(1);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL cofs_dp_n37 got=%b exp=1", dp); end
   endtask

   task automatic test_co_level();
      count = 7'h00;
      do_reset();
      go(10);
      co = 1'b1;
      go(3);
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL colvl_dp_n13 got=%b exp=0", dp); end
      go(16);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL colvl_dp_n29 got=%b exp=1", dp); end
      go(12);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL colvl_dp_n41 got=%b exp=1", dp); end
      co = 1'b0;
   endtask

   task automatic test_illegal();
      count = 7'h3A;
      do_reset();
      go(5);
      checks++; if (seg !== GD) begin errors++; $display("FAIL illegal_ones got=%b exp=%b", seg, GD); end
      go(4);
      checks++; if (seg !== G3) begin errors++; $display("FAIL illegal_ones_tens got=%b exp=%b", seg, G3); end
      count = 7'h65;
      do_reset();
      go(5);
      checks++; if (seg !== G5) begin errors++; $display("FAIL illegal_tens_ones got=%b exp=%b", seg, G5); end
      go(4);
      checks++; if (seg !== GD) begin errors++; $display("FAIL illegal_tens got=%b exp=%b", seg, GD); end
   endtask

   task automatic test_lead_zero();
      logic [6:0] exp_tens;
`ifdef LEAD_ZERO_BLANK_EN
      exp_tens = GB;
`else
      exp_tens = G0;
`endif
      count = 7'h05;
      do_reset();
      go(5);
      checks++; if (seg !== G5) begin errors++; $display("FAIL lz_ones got=%b exp=%b", seg, G5); end
      go(4);
      checks++; if (an !== 2'b01 || seg !== exp_tens) begin errors++; $display("FAIL lz_tens got=%b/%b exp=01/%b", an, seg, exp_tens); end
   endtask

   task automatic test_reset_mid_hold();
      count = 7'h12;
      do_reset();
      go(10);
      co = 1'b1;
      go(1);
      co = 1'b0;
      go(5);
      checks++; if (dp !== 1'b0) begin errors++; $display("FAIL rmh_dp_pre got=%b exp=0", dp); end
      #2 rst = 1'b0;
      #1;
      checks++; if (seg !== GB || an !== 2'b11 || dp !== 1'b1) begin errors++; $display("FAIL rmh_dark got=%b/%b/%b exp=%b/11/1", seg, an, dp, GB); end
      go(2);
      rst = 1'b1;
      go(5);
      checks++; if (an !== 2'b10 || seg !== G2) begin errors++; $display("FAIL rmh_ones got=%b/%b exp=10/%b", an, seg, G2); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rmh_dp_n5 got=%b exp=1", dp); end
      go(8);
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rmh_dp_n13 got=%b exp=1", dp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_freeze();
      test_carry();
      test_co_at_frame_start();
      test_co_level();
      test_illegal();
      test_lead_zero();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_scan_60.md
SEG_SCAN_60 -- requirements
Module: seg_scan_60

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter CO_HOLD, default 4: scan frames for which dp stays lit after a carry; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 count  input  7  BCD seconds from the upstream 0..59 counter: [6:4] tens (0..5), [3:0] ones (0..9).
REQ-006 co  input  1  carry level from the upstream counter; high while it wraps 59->0.
REQ-007 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 dp  output  1  decimal point, active-low, registered.
REQ-009 an  output  2  digit enables, active-low, one-hot-low, registered: an[0] ones, an[1] tens.

Function
REQ-010 The prescaler counts 0..SCAN_DIV-1 and wraps; tick is high for the one cycle with prescaler == SCAN_DIV-1.
REQ-011 Digit select sel toggles on every tick: sel 0 = ones slot, sel 1 = tens slot; one frame = two slots.
REQ-012 Frame start is the tick on which sel goes 1->0.
REQ-013 The shadow register captures count only at frame start, so one frame never mixes two count values.
REQ-014 seg, an and dp update on the clock edge after the tick; latency from tick to new digit is 1 cycle.
REQ-015 While sel = 0: an = 2'b10, seg = glyph(shadow[3:0]). While sel = 1: an = 2'b01, seg = glyph(shadow[6:4]).
REQ-016 Glyphs use the standard 7-segment patterns; 0 -> 7'b1000000, 1 -> 7'b1111001, 5 -> 7'b0010010, 9 -> 7'b0010000.
REQ-017 Illegal digits (ones > 9 or tens > 5) display '-' (7'b0111111) in that slot only.
REQ-018 A rising edge of co is detected against a registered copy of co; a level held high counts as one edge.
REQ-019 A co edge loads hold = CO_HOLD; at each frame start with hold > 0 and no co edge, hold decrements by 1.
REQ-020 A co edge and a frame start in the same cycle load CO_HOLD; the load takes priority over the decrement.
REQ-021 dp = 0 (lit) in both slots while hold > 0, otherwise 1.
REQ-022 A co edge during an active hold reloads CO_HOLD; holds do not accumulate.

Reset
REQ-023 rst low clears the prescaler, sel, shadow, the co delay register and hold to 0 immediately, independent of clk.
REQ-024 During reset: seg = 7'b1111111, dp = 1, an = 2'b11, i.e. the display is fully dark.
REQ-025 After rst releases, the first display update occurs 1 cycle after the first tick, in the ones slot.
REQ-026 Reset asserted mid-frame or mid-hold discards all partial state; no dp is shown after release unless a new co edge arrives.

Configuration
REQ-027 Macro LEAD_ZERO_BLANK_EN: when defined, a tens digit of 0 blanks the tens slot (seg = 7'b1111111, an[1] still 0); the dp rule still applies.
REQ-028 Without LEAD_ZERO_BLANK_EN, a tens digit of 0 displays glyph 0; all other behaviour is identical in both builds.

Verification (SCAN_DIV=4, CO_HOLD=2)
REQ-029 Reset, then count=7'h37 held -> an alternates 10/01 every 4 cycles; seg shows 7 then 3; dp=1 throughout.
REQ-030 count changes from 7'h12 to 7'h45 mid tens slot -> the rest of that frame still shows 2/1; the next frame shows 5/4.
REQ-031 One co pulse one cycle before a frame start -> dp=0 for exactly 2 frames (16 cycles of display), then 1.
REQ-032 count=7'h3A -> ones slot shows 7'b0111111 and tens slot shows 3; count=7'h65 -> tens slot shows '-'.
REQ-033 count=7'h05 -> tens slot is 7'b1111111 with LEAD_ZERO_BLANK_EN defined and 7'b1000000 without it.
REQ-034 rst pulsed low mid-frame with hold=1 -> outputs go dark asynchronously; after release dp=1 and display restarts in the ones slot.
